data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the ALU-to-data-memory interface: takes the word address
//  (ram_address) plus write data from the datapath and services load/store
//  requests against an internal word RAM with programmable wait states.
//  Sits between the ALU/datapath and data storage; busy stalls the PC/pipeline.
// PARAMETERS
//  ADDR_W    10    word-address width (matches the ALU ram_address width)
//  DEPTH     1024  implemented words; legal range 1..2**ADDR_W
//  WAIT_CYC  2     wait states per access, 0..15
// PORTS
//  clk    in   1       rising-edge clock
//  reset  in   1       asynchronous, active-low reset
//  req    in   1       access request; hold until accepted
//  we     in   1       1=store, 0=load; sampled with req
//  addr   in   ADDR_W  word address
//  wdata  in   32      store data
//  be     in   4       byte enables, be[0]=bits 7:0; used only with macro
//  ready  out  1       high in IDLE; request accepted when req&&ready
//  busy   out  1       high while an access is in flight (stall)
//  done   out  1       one-cycle completion pulse
//  rdata  out  32      load data, valid when done&&!we_latched
//  err    out  1       addr>=DEPTH; valid with done
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, wait counter=0, ready=1, busy=0,
//    done=0, rdata=0, err=0, latched request cleared. RAM contents are NOT
//    cleared and keep their values.
//  - FSM: IDLE -> WAIT (if WAIT_CYC>0) -> RESP -> IDLE; IDLE -> RESP when WAIT_CYC=0.
//    IDLE: ready=1; on req: latch we/addr/wdata/be, load counter=WAIT_CYC.
//    WAIT: counter decrements each cycle; leaves to RESP on the edge where
//      counter==1.
//    RESP: done=1 for exactly one cycle, then IDLE.
//  - Latency: done rises WAIT_CYC+1 cycles after the accepting edge.
//    Back-to-back accepts are separated by at least WAIT_CYC+2 cycles.
//  - The RAM write commits and the RAM read samples on the edge entering RESP.
//    The value a load returns is the RAM content at that edge, so a load
//    issued after a completed store to the same address returns the new data.
//  - rdata: updated only for in-range loads; forced to 0 on err; holds its
//    previous value through stores and idle cycles.
//  - Out of range (addr>=DEPTH): no RAM write, err=1 and rdata=0 in RESP.
//    Addresses never wrap.
//  - req while busy: ignored; no queueing. Requester holds req, which is
//    accepted in the IDLE cycle after done.
//  - If reset asserts mid-access, the access is aborted: no write commits and
//    no done is issued.
//  - busy = (state != IDLE); ready = ~busy.
// CONFIGURATION
//  DATA_MEM_BYTE_EN_EN defined: stores write only the bytes with be[i]=1;
//    be=4'b0000 is a no-op store, still completes with done=1.
//  Not defined: be is ignored and every store writes the full 32-bit word.
//    Loads always return the full word either way.
// TESTING
//  1 WAIT_CYC=2: store 0xDEADBEEF @5; then load @5 -> done 3 cycles after each
//    accept, rdata=0xDEADBEEF, err=0.
//  2 DEPTH=512: store 0x12345678 @600 -> done with err=1, rdata=0; then load @88
//    (88=600 mod 512) -> prior contents, unchanged.
//  3 Hold req through a busy access -> no second accept; next accept exactly
//    1 cycle after done; busy high for each whole access.
//  4 Drop reset mid-WAIT during store 0xCAFEF00D @9 (old 0x0) -> done never
//    pulses; after release ready=1; load @9 returns 0x0.
//  5 Macro on: @3=0x11223344, store 0xAABBCCDD be=0011 -> load 0x1122CCDD;
//    macro off: load 0xAABBCCDD.
//  6 WAIT_CYC=0: load @0 -> done on the cycle after the accept; back-to-back
//    loads accepted every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Load/store responder for the datapath's data-memory port: internal word RAM serviced
// with WAIT_CYC wait states. Define DATA_MEM_BYTE_EN_EN to honour i_be on stores.
module data_mem_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_be,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [2**IDX_W];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_cur_we;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [31:0]       w_cur_wdata;
  logic [3:0]        w_cur_be;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_commit;

  assign w_accept = (r_state == StIdle) && i_req;

  // With no wait states the access resolves on its accepting edge, using the live inputs.
  assign w_enter_resp = (WAIT_CYC == 0) ? w_accept
                                        : ((r_state == StWait) && (r_cnt == 4'd1));
  assign w_cur_we    = (r_state == StIdle) ? i_we    : r_we;
  assign w_cur_addr  = (r_state == StIdle) ? i_addr  : r_addr;
  assign w_cur_wdata = (r_state == StIdle) ? i_wdata : r_wdata;

`ifdef DATA_MEM_BYTE_EN_EN
  assign w_cur_be = (r_state == StIdle) ? i_be : r_be;
`else
  logic w_unused_be;
  assign w_cur_be    = 4'hF;
  assign w_unused_be = ^{i_be, r_be};
`endif

  assign w_in_range = (32'(w_cur_addr) < DEPTH);
  assign w_idx      = w_cur_addr[IDX_W-1:0];
  // Gate on reset so an access accepted while reset is low can never commit.
  assign w_commit   = w_enter_resp && w_cur_we && w_in_range && i_rst_n;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_commit && w_cur_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_done <= w_enter_resp;
      if (w_enter_resp) begin
        r_err <= !w_in_range;
        if (!w_in_range) begin
          r_rdata <= 32'd0;
        end else if (!w_cur_we) begin
          r_rdata <= r_mem[w_idx];
        end
      end else begin
        r_err <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_be    <= i_be;
            r_cnt   <= WAIT_INIT;
            r_state <= (WAIT_CYC == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= StResp;
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy  = (r_state != StIdle);
  assign o_ready = ~o_busy;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench: two responders (2 wait states / DEPTH 512, and
// 0 wait states / DEPTH 1000) checked against an array-based memory model.
module tb_data_mem_responder;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_s   [2];
  logic          we_s    [2];
  logic [AW-1:0] addr_s  [2];
  logic [31:0]   wdata_s [2];
  logic [3:0]    be_s    [2];
  logic          ready_o [2];
  logic          busy_o  [2];
  logic          done_o  [2];
  logic          err_o   [2];
  logic [31:0]   rdata_o [2];

  logic [31:0]   mdl     [2][1024];
  logic [31:0]   last_rd [2];
  int            n_total = 0;
  int            n_pass  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(AW), .DEPTH(512), .WAIT_CYC(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_s[0]), .i_we(we_s[0]), .i_addr(addr_s[0]),
    .i_wdata(wdata_s[0]), .i_be(be_s[0]), .o_ready(ready_o[0]), .o_busy(busy_o[0]),
    .o_done(done_o[0]), .o_rdata(rdata_o[0]), .o_err(err_o[0])
  );

  data_mem_responder #(.ADDR_W(AW), .DEPTH(1000), .WAIT_CYC(0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_s[1]), .i_we(we_s[1]), .i_addr(addr_s[1]),
    .i_wdata(wdata_s[1]), .i_be(be_s[1]), .o_ready(ready_o[1]), .o_busy(busy_o[1]),
    .o_done(done_o[1]), .o_rdata(rdata_o[1]), .o_err(err_o[1])
  );

  function automatic int unsigned depth_of(input int s);
    return (s == 0) ? 512 : 1000;
  endfunction

  function automatic int unsigned wait_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  // Memory word after a store of d with byte enables b.
  function automatic logic [31:0] store_result(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] b);
    logic [31:0] r;
    logic [3:0]  eff;
    r   = old;
    eff = b;
`ifndef DATA_MEM_BYTE_EN_EN
    eff = 4'hF;
`endif
    for (int i = 0; i < 4; i++) if (eff[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic wait_ready(input int s, input string tag);
    int n;
    n = 0;
    while (ready_o[s] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ready_o[s]), 32'd1);
  endtask

  // One complete access: latency, busy, err, rdata and the one-cycle done pulse.
  task automatic access(input int s, input bit we, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    int          lat;
    bit          bad_busy;
    bit          oor;
    logic [31:0] exp_rd;
    @(negedge clk);
    req_s[s] = 1'b1; we_s[s] = we; addr_s[s] = a; wdata_s[s] = d; be_s[s] = b;
    wait_ready(s, "accept");
    @(posedge clk);
    #1;
    req_s[s]   = 1'b0;
    we_s[s]    = 1'($urandom_range(0, 1));
    addr_s[s]  = AW'($urandom);
    wdata_s[s] = $urandom;
    be_s[s]    = 4'($urandom);
    lat = 0;
    bad_busy = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy_o[s] !== 1'b1) bad_busy = 1'b1;
      if (done_o[s] === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'(wait_of(s) + 1));
    check("busy_in_flight", 32'(bad_busy), 32'd0);
    oor = (32'(a) >= depth_of(s));
    if (oor) begin
      exp_rd = 32'd0;
    end else if (we) begin
      mdl[s][a] = store_result(mdl[s][a], d, b);
      exp_rd = last_rd[s];
    end else begin
      exp_rd = mdl[s][a];
    end
    last_rd[s] = exp_rd;
    check("err", 32'(err_o[s]), 32'(oor));
    check("rdata", rdata_o[s], exp_rd);
    @(negedge clk);
    check("done_one_cycle", 32'(done_o[s]), 32'd0);
    check("ready_after_done", 32'(ready_o[s]), 32'd1);
  endtask

  // Load held through two accesses: second accept lands one cycle after the first done.
  task automatic hold_test(input int s, input logic [AW-1:0] a);
    int          w;
    int          d1;
    int          d2;
    int          nd;
    bit          bad_busy;
    logic [31:0] rd2;
    w = int'(wait_of(s));
    d1 = -1; d2 = -1; nd = 0; bad_busy = 1'b0; rd2 = 32'd0;
    @(negedge clk);
    req_s[s] = 1'b1; we_s[s] = 1'b0; addr_s[s] = a; wdata_s[s] = 32'd0; be_s[s] = 4'hF;
    wait_ready(s, "hold_accept");
    for (int i = 1; i <= 2 * w + 3; i++) begin
      @(negedge clk);
      if (done_o[s] === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = i;
        else d2 = i;
        rd2 = rdata_o[s];
      end
      if (i == w + 2) check("hold_rearm_ready", 32'(ready_o[s]), 32'd1);
      else if (busy_o[s] !== 1'b1) bad_busy = 1'b1;
    end
    req_s[s] = 1'b0;
    last_rd[s] = mdl[s][a];
    check("hold_n_done", 32'(nd), 32'd2);
    check("hold_first_done", 32'(d1), 32'(w + 1));
    check("hold_second_done", 32'(d2), 32'(2 * w + 3));
    check("hold_busy", 32'(bad_busy), 32'd0);
    check("hold_rdata", rd2, mdl[s][a]);
    @(negedge clk);
    check("hold_no_third", 32'(busy_o[s]), 32'd0);
  endtask

  task automatic check_reset_state(input int s);
    check("rst_ready", 32'(ready_o[s]), 32'd1);
    check("rst_busy", 32'(busy_o[s]), 32'd0);
    check("rst_done", 32'(done_o[s]), 32'd0);
    check("rst_err", 32'(err_o[s]), 32'd0);
    check("rst_rdata", rdata_o[s], 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bit          seen_done;
    bit          bad_ready;
    bit          we;
    int unsigned a;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = '0; wdata_s[s] = 32'd0; be_s[s] = 4'd0;
      last_rd[s] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) check_reset_state(s);
    rst_n = 1'b1;

    // Known contents for the address pool used below.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) access(s, 1'b1, AW'(i), $urandom, 4'hF);
      access(s, 1'b1, AW'(88), $urandom, 4'hF);
      access(s, 1'b1, AW'(9), 32'd0, 4'hF);
    end

    access(0, 1'b1, AW'(5), 32'hDEADBEEF, 4'hF);
    access(0, 1'b0, AW'(5), 32'd0, 4'hF);
    check("load_after_store", rdata_o[0], 32'hDEADBEEF);

    access(0, 1'b1, AW'(600), 32'h12345678, 4'hF);
    access(0, 1'b0, AW'(88), 32'd0, 4'hF);

    for (int s = 0; s < 2; s++) begin
      access(s, 1'b1, AW'(3), 32'h11223344, 4'hF);
      access(s, 1'b1, AW'(3), 32'hAABBCCDD, 4'b0011);
      access(s, 1'b0, AW'(3), 32'd0, 4'hF);
`ifdef DATA_MEM_BYTE_EN_EN
      check("byte_en_merge", rdata_o[s], 32'h1122CCDD);
`else
      check("byte_en_ignored", rdata_o[s], 32'hAABBCCDD);
`endif
      access(s, 1'b1, AW'(3), 32'h55667788, 4'b0000);
      access(s, 1'b0, AW'(3), 32'd0, 4'hF);
    end

    hold_test(0, AW'(5));
    hold_test(1, AW'(7));

    // Reset in the middle of a store's wait states.
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = AW'(9); wdata_s[0] = 32'hCAFEF00D;
    be_s[0] = 4'hF;
    wait_ready(0, "rst_accept");
    @(posedge clk);
    #1;
    req_s[0] = 1'b0;
    @(negedge clk);
    check("rst_busy_before", 32'(busy_o[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state(0);
    check("rst_rdata_other", rdata_o[1], 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    seen_done = 1'b0;
    bad_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) seen_done = 1'b1;
      if (ready_o[0] !== 1'b1) bad_ready = 1'b1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    check("rst_ready_after", 32'(bad_ready), 32'd0);
    access(0, 1'b0, AW'(9), 32'd0, 4'hF);
    check("rst_no_commit", rdata_o[0], 32'd0);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 60; k++) begin
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) a = $urandom_range(1023, depth_of(s));
        else begin
          a = $urandom_range(0, 16);
          if (a == 16) a = 88;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        access(s, we, AW'(a), $urandom, 4'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
